// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and init ROM for the LCD write scheduler.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_LOAD = 3'd0,
        IDLE      = 3'd1,
        SETUP     = 3'd2,
        EN_HI     = 3'd3,
        HOLD      = 3'd4,
        WAIT      = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;

    localparam int INIT_LEN   = 4;
    localparam int INIT_IDX_W = 2;

    // Entry 0 sits in the low byte and is issued first.
    localparam logic [8*INIT_LEN-1:0] INIT_ROM = {CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON, CMD_FUNC_SET};

    function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
        return INIT_ROM[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return (rs == 1'b0) && ((dat == CMD_CLEAR) || (dat == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_write_scheduler_if.sv
// Client request/ack handshake and LCD pin bundle of the LCD write scheduler.
interface lcd_write_scheduler_if;

    logic       req0;
    logic       req1;
    logic       rs0;
    logic       rs1;
    logic [7:0] dat0;
    logic [7:0] dat1;
    logic       ack0;
    logic       ack1;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;
    logic       busy;
    logic       init_done;

    modport master (
        output req0, req1, rs0, rs1, dat0, dat1,
        input  ack0, ack1, lcd_rs, lcd_rw, lcd_en, lcd_dat, busy, init_done
    );

    modport slave (
        input  req0, req1, rs0, rs1, dat0, dat1,
        output ack0, ack1, lcd_rs, lcd_rw, lcd_en, lcd_dat, busy, init_done
    );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is accepted.
module lcd_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic accept_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic prio1_q;
    logic prio1_d;

    // A lone request wins outright; on contention the side not granted last wins.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (req0_i && req1_i) begin
            gnt0_o = ~prio1_q;
            gnt1_o = prio1_q;
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end
    end

    always_comb begin
        prio1_d = prio1_q;
        if (accept_i && gnt0_o) begin
            prio1_d = 1'b1;
        end else if (accept_i && gnt1_o) begin
            prio1_d = 1'b0;
        end else begin
            prio1_d = prio1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio1_q <= 1'b0;
        end else begin
            prio1_q <= prio1_d;
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shared HD44780 write controller: arbitrates two clients and drives RS/DATA/E bus timing.
// Define LCD_INIT_SEQ_EN to issue the power-up command sequence after reset.
module lcd_write_scheduler
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int SHORT_WAIT = 2000,
    parameter int LONG_WAIT  = 82000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_write_scheduler_if.slave bus
);

    localparam int CNT_MAX = (LONG_WAIT > CLK_DIV) ? LONG_WAIT : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_WAIT);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT);

`ifdef LCD_INIT_SEQ_EN
    localparam lcd_state_e RST_STATE     = INIT_LOAD;
    localparam logic       RST_INIT_DONE = 1'b1 ^ 1'b1;
    localparam logic       RST_BUSY      = 1'b1;
    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);
    logic [INIT_IDX_W-1:0] init_idx_q;
`else
    localparam lcd_state_e RST_STATE     = IDLE;
    localparam logic       RST_INIT_DONE = 1'b1;
    localparam logic       RST_BUSY      = 1'b0;
`endif

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rs_q;
    logic [7:0]       dat_q;
    logic             en_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             busy_q;
    logic             init_done_q;

    logic accept_s;
    logic gnt0_s;
    logic gnt1_s;

    assign accept_s = (state_q == IDLE) && init_done_q && (bus.req0 || bus.req1);

    lcd_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .accept_i (accept_s),
        .gnt0_o   (gnt0_s),
        .gnt1_o   (gnt1_s)
    );

    // Transfer FSM; each phase counter reloads on state entry and leaves the state at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            cnt_q       <= CNT_ONE;
            rs_q        <= 1'b0;
            dat_q       <= 8'h00;
            en_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= RST_BUSY;
            init_done_q <= RST_INIT_DONE;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q  <= '0;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                INIT_LOAD: begin
`ifdef LCD_INIT_SEQ_EN
                    rs_q    <= 1'b0;
                    dat_q   <= init_cmd(init_idx_q);
                    cnt_q   <= PHASE_LOAD;
                    state_q <= SETUP;
                    busy_q  <= 1'b1;
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                IDLE: begin
                    if (accept_s) begin
                        rs_q    <= gnt1_s ? bus.rs1 : bus.rs0;
                        dat_q   <= gnt1_s ? bus.dat1 : bus.dat0;
                        ack0_q  <= gnt0_s;
                        ack1_q  <= gnt1_s;
                        cnt_q   <= PHASE_LOAD;
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_ONE) begin
                        en_q    <= 1'b1;
                        cnt_q   <= PHASE_LOAD;
                        state_q <= EN_HI;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                EN_HI: begin
                    if (cnt_q == CNT_ONE) begin
                        en_q    <= 1'b0;
                        cnt_q   <= PHASE_LOAD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_q   <= is_long_cmd(rs_q, dat_q) ? LONG_LOAD : SHORT_LOAD;
                        state_q <= WAIT;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_ONE) begin
`ifdef LCD_INIT_SEQ_EN
                        if (!init_done_q && (init_idx_q != INIT_LAST)) begin
                            init_idx_q <= init_idx_q + 1'b1;
                            state_q    <= INIT_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= RST_STATE;
                    busy_q  <= RST_BUSY;
                end
            endcase
        end
    end

    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_en    = en_q;
    assign bus.lcd_dat   = dat_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed scoreboard bench for lcd_write_scheduler (honours LCD_INIT_SEQ_EN when defined).
module tb_lcd_write_scheduler;

    localparam int CLK_DIV    = 2;
    localparam int SHORT_WAIT = 5;
    localparam int LONG_WAIT  = 20;

`ifdef LCD_INIT_SEQ_EN
    localparam logic RST_DONE = 1'b0;
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_DONE = 1'b1;
    localparam logic RST_BUSY = 1'b0;
`endif

    typedef struct packed {
        logic       client;
        logic       rs;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_write_scheduler_if bus();

    lcd_write_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .SHORT_WAIT (SHORT_WAIT),
        .LONG_WAIT  (LONG_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       cur_rs  = 1'b0;
    logic [7:0] cur_dat = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input logic client, input logic rs, input logic [7:0] dat);
        exp_t e;
        e.client = client;
        e.rs     = rs;
        e.dat    = dat;
        sb_q.push_back(e);
    endtask

    task automatic request(input logic client, input logic rs, input logic [7:0] dat);
        if (client == 1'b0) begin
            bus.req0 = 1'b1; bus.rs0 = rs; bus.dat0 = dat;
        end else begin
            bus.req1 = 1'b1; bus.rs1 = rs; bus.dat1 = dat;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_en"},        {31'd0, bus.lcd_en},    32'd0);
        check({tag, "_rs"},        {31'd0, bus.lcd_rs},    32'd0);
        check({tag, "_dat"},       {24'd0, bus.lcd_dat},   32'd0);
        check({tag, "_rw"},        {31'd0, bus.lcd_rw},    32'd0);
        check({tag, "_ack0"},      {31'd0, bus.ack0},      32'd0);
        check({tag, "_ack1"},      {31'd0, bus.ack1},      32'd0);
        check({tag, "_init_done"}, {31'd0, bus.init_done}, {31'd0, RST_DONE});
        check({tag, "_busy"},      {31'd0, bus.busy},      {31'd0, RST_BUSY});
    endtask

    // Waits for init_done while the init commands go out; any ack in the meantime is an error.
    task automatic wait_init(input string tag);
`ifdef LCD_INIT_SEQ_EN
        logic [7:0] rom [4];
        int   npulse  = 0;
        int   len     = 0;
        int   fall_at = -1;
        int   done_at = -1;
        int   acks    = 0;
        logic prev_en = 1'b0;
        rom = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
            if (bus.lcd_en) len++;
            if (bus.lcd_en && !prev_en && npulse < 4)
                check({tag, "_init_cmd"}, {24'd0, bus.lcd_dat}, {24'd0, rom[npulse]});
            if (!bus.lcd_en && prev_en) begin
                check({tag, "_init_en_len"}, len, CLK_DIV);
                len = 0;
                npulse++;
                fall_at = i;
            end
            prev_en = bus.lcd_en;
            if (bus.init_done) begin
                done_at = i;
                break;
            end
        end
        check({tag, "_init_pulses"}, npulse, 4);
        check({tag, "_init_clear_gap"}, done_at - fall_at, CLK_DIV + LONG_WAIT);
        check({tag, "_init_no_ack"}, acks, 0);
`else
        check({tag, "_init_done"}, {31'd0, bus.init_done}, 32'd1);
        check({tag, "_idle"},      {31'd0, bus.busy},      32'd0);
`endif
    endtask

    // Waits for an ack and compares the granted client and latched RS/DATA with the scoreboard.
    task automatic wait_ack(input string tag, input int bound, output int waited, input bit keep);
        exp_t e;
        logic got = 1'b0;
        waited = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got    = 1'b1;
                waited = i;
                break;
            end
        end
        check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_ack_onehot"}, {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            check({tag, "_busy_on_ack"}, {31'd0, bus.busy}, 32'd1);
            check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({tag, "_client"}, {31'd0, bus.ack1}, {31'd0, e.client});
                check({tag, "_rs"},     {31'd0, bus.lcd_rs}, {31'd0, e.rs});
                check({tag, "_dat"},    {24'd0, bus.lcd_dat}, {24'd0, e.dat});
                cur_rs  = e.rs;
                cur_dat = e.dat;
            end
            if (!keep) begin
                if (bus.ack0) bus.req0 = 1'b0;
                else          bus.req1 = 1'b0;
            end
        end
    endtask

    // Follows a transfer from its ack until busy drops and checks the bus timing.
    task automatic watch(input string tag, input int wait_cycles);
        int en_rise   = -1;
        int en_len    = 0;
        int fall      = -1;
        int extra_ack = 0;
        int dat_bad   = 0;
        int rw_bad    = 0;
        for (int i = 2; i <= 200; i++) begin
            @(negedge clk);
            if (bus.lcd_en) begin
                en_len++;
                if (en_rise < 0) en_rise = i;
            end
            if (bus.ack0 || bus.ack1) extra_ack++;
            if (bus.lcd_dat !== cur_dat || bus.lcd_rs !== cur_rs) dat_bad++;
            if (bus.lcd_rw !== 1'b0) rw_bad++;
            if (!bus.busy) begin
                fall = i;
                break;
            end
        end
        check({tag, "_en_rise"},   en_rise, CLK_DIV + 1);
        check({tag, "_en_len"},    en_len, CLK_DIV);
        check({tag, "_busy_fall"}, fall, 1 + 3 * CLK_DIV + wait_cycles);
        check({tag, "_ack_pulse"}, extra_ack, 0);
        check({tag, "_bus_stable"}, dat_bad, 0);
        check({tag, "_rw_low"},    rw_bad, 0);
    endtask

    initial begin
        int   w;
        logic got;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.rs0  = 1'b0; bus.rs1  = 1'b0;
        bus.dat0 = 8'h00; bus.dat1 = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        wait_init("por");

        // Simultaneous requests with the pointer at its reset value: client 0, then client 1.
        expect_grant(1'b0, 1'b1, 8'h41);
        expect_grant(1'b1, 1'b1, 8'h42);
        request(1'b0, 1'b1, 8'h41);
        request(1'b1, 1'b1, 8'h42);
        wait_ack("both_a", 4, w, 1'b0);
        check("both_a_lat", w, 1);
        watch("both_a", SHORT_WAIT);
        wait_ack("both_b", 4, w, 1'b0);
        check("both_b_b2b_lat", w, 1);
        watch("both_b", SHORT_WAIT);

        // Single data write of 'C'.
        expect_grant(1'b0, 1'b1, 8'h43);
        request(1'b0, 1'b1, 8'h43);
        wait_ack("single", 4, w, 1'b0);
        check("single_lat", w, 1);
        watch("single", SHORT_WAIT);

        // Both held high: grants alternate starting with client 1.
        expect_grant(1'b1, 1'b1, 8'h61);
        expect_grant(1'b0, 1'b1, 8'h60);
        expect_grant(1'b1, 1'b1, 8'h61);
        expect_grant(1'b0, 1'b1, 8'h60);
        request(1'b0, 1'b1, 8'h60);
        request(1'b1, 1'b1, 8'h61);
        for (int k = 0; k < 4; k++) begin
            wait_ack("alt", 4, w, 1'b1);
            check("alt_lat", w, 1);
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            watch("alt", SHORT_WAIT);
        end

        // Long waits only for clear/home commands.
        expect_grant(1'b1, 1'b0, 8'h01);
        request(1'b1, 1'b0, 8'h01);
        wait_ack("clear", 4, w, 1'b0);
        watch("clear", LONG_WAIT);
        expect_grant(1'b1, 1'b1, 8'h01);
        request(1'b1, 1'b1, 8'h01);
        wait_ack("data01", 4, w, 1'b0);
        watch("data01", SHORT_WAIT);
        expect_grant(1'b0, 1'b0, 8'h02);
        request(1'b0, 1'b0, 8'h02);
        wait_ack("home", 4, w, 1'b0);
        watch("home", LONG_WAIT);
        expect_grant(1'b0, 1'b0, 8'h03);
        request(1'b0, 1'b0, 8'h03);
        wait_ack("cmd03", 4, w, 1'b0);
        watch("cmd03", SHORT_WAIT);

        // Reset while E is high, with client 0 pending behind the transfer.
        expect_grant(1'b1, 1'b1, 8'h55);
        expect_grant(1'b0, 1'b1, 8'h56);
        request(1'b1, 1'b1, 8'h55);
        wait_ack("rst_xfer", 4, w, 1'b0);
        request(1'b0, 1'b1, 8'h56);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.lcd_en) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_en_seen", {31'd0, got}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid");
        rst_n = 1'b1;
        wait_init("mid");
        wait_ack("regrant", 4, w, 1'b0);
        check("regrant_lat", w, 1);
        watch("regrant", SHORT_WAIT);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
